// File: rtl/a2s_pkg.sv
// a2s_pkg
//   Shared definitions for the A2S stream unpacker: FSM state encoding and the
//   field layout of a 32-bit buffer word ({Q[31:16], I[15:0]}, two's complement).
//   Ports: none (package).
package a2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } a2s_state_e;

    localparam int I_LSB = 0;
    localparam int Q_LSB = 16;
    localparam int SMP_W = 16;

    function automatic logic [SMP_W-1:0] word_i(input logic [31:0] w);
        return w[I_LSB +: SMP_W];
    endfunction

    function automatic logic [SMP_W-1:0] word_q(input logic [31:0] w);
        return w[Q_LSB +: SMP_W];
    endfunction

endpackage

// File: rtl/a2s_stream_unpacker_if.sv
// a2s_stream_unpacker_if
//   Groups the buffer read port and the TX sample stream of the unpacker.
//   master: the unpacker (drives a2s_oen, tx_valid, tx_i, tx_q).
//   slave : the environment (ping-pong buffer + TX sink).
//   Signals:
//     a2s_oen    buffer read enable, one word per high cycle
//     a2s_rdata  buffer read data, valid the cycle after a2s_oen
//     tx_valid   sample valid
//     tx_ready   sink accepts sample
//     tx_i/tx_q  rounded I/Q sample, OUT_W bits each
interface a2s_stream_unpacker_if #(
    parameter int OUT_W = 12
);
    logic             a2s_oen;
    logic [31:0]      a2s_rdata;
    logic             tx_valid;
    logic             tx_ready;
    logic [OUT_W-1:0] tx_i;
    logic [OUT_W-1:0] tx_q;

    modport master (
        output a2s_oen,
        input  a2s_rdata,
        output tx_valid,
        input  tx_ready,
        output tx_i,
        output tx_q
    );

    modport slave (
        input  a2s_oen,
        output a2s_rdata,
        input  tx_valid,
        output tx_ready,
        input  tx_i,
        input  tx_q
    );
endinterface

// File: rtl/a2s_round_sat.sv
// a2s_round_sat
//   Combinational round-half-up and positive saturation of one 16-bit signed
//   sample down to OUT_W bits.
//   Ports:
//     x_i    16-bit signed input sample
//     y_o    OUT_W-bit rounded result
//     sat_o  high when the rounded value was clamped to the maximum
module a2s_round_sat #(
    parameter int OUT_W = 12
) (
    input  logic [15:0]      x_i,
    output logic [OUT_W-1:0] y_o,
    output logic             sat_o
);
    localparam int S = 16 - OUT_W;

    generate
        if (S == 0) begin : g_pass
            assign y_o   = x_i;
            assign sat_o = 1'b0;
        end else begin : g_round
            localparam logic signed [16:0] HALF = 17'sd1 <<< (S - 1);
            localparam logic signed [16:0] MAXV = (17'sd1 <<< (OUT_W - 1)) - 17'sd1;

            logic signed [16:0] sum;
            logic signed [16:0] y;

            // 17 bits keep x + half from wrapping at the positive end; the
            // arithmetic shift floors, so the negative minimum always fits.
            assign sum   = $signed({x_i[15], x_i}) + HALF;
            assign y     = sum >>> S;
            assign sat_o = (y > MAXV);
            assign y_o   = sat_o ? MAXV[OUT_W-1:0] : y[OUT_W-1:0];
        end
    endgenerate
endmodule

// File: rtl/a2s_stream_unpacker.sv
// a2s_stream_unpacker
//   Sclk-domain reader of the A2S ping-pong buffer. Issues buffer reads,
//   captures each word one cycle later, rounds I/Q to OUT_W bits and queues
//   them in a small show-ahead FIFO feeding a valid/ready TX stream.
//   Ports:
//     Sclk      stream clock
//     rst_n     asynchronous active-low reset
//     sync      synchronous restart (same effect as reset)
//     en        stream enable
//     bus       master side of a2s_stream_unpacker_if (buffer read + TX stream)
//     underrun  sticky: tx_ready seen in RUN with FIFO empty
//     sat_flag  sticky: a written sample saturated
//     smp_cnt   count of accepted samples
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | stopped, waiting for en
//   ST_PRIME | wait PRIME_CYCLES so the upstream can fill the buffer
//   ST_RUN   | reading words while FIFO + in-flight has room
//   ST_DRAIN | en dropped: no new reads, deliver what is left, then IDLE
module a2s_stream_unpacker
    import a2s_pkg::*;
#(
    parameter int OUT_W        = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int PRIME_CYCLES = 64,
    parameter int CNT_W        = 32
) (
    input  logic                  Sclk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic                  en,
    a2s_stream_unpacker_if.master bus,
    output logic                  underrun,
    output logic                  sat_flag,
    output logic [CNT_W-1:0]      smp_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

    a2s_state_e       state_q;
    logic [PW-1:0]    prime_q;
    logic             inflight_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic             underrun_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;

    logic [OUT_W-1:0] mem_i_q [FIFO_DEPTH];
    logic [OUT_W-1:0] mem_q_q [FIFO_DEPTH];

    logic [15:0]      smp_i;
    logic [15:0]      smp_q;
    logic [OUT_W-1:0] rnd_i;
    logic [OUT_W-1:0] rnd_q;
    logic             sat_i;
    logic             sat_qc;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             oen;
    logic [CW:0]      occ;

    assign smp_i = word_i(bus.a2s_rdata);
    assign smp_q = word_q(bus.a2s_rdata);

    a2s_round_sat #(.OUT_W(OUT_W)) u_round_i (
        .x_i   (smp_i),
        .y_o   (rnd_i),
        .sat_o (sat_i)
    );

    a2s_round_sat #(.OUT_W(OUT_W)) u_round_q (
        .x_i   (smp_q),
        .y_o   (rnd_q),
        .sat_o (sat_qc)
    );

    assign fifo_empty = (count_q == '0);
    // rdata is only meaningful when a read was issued last cycle; a sync
    // clears inflight_q, which is what discards the word after a sync.
    assign push       = inflight_q;
    assign pop        = bus.tx_valid & bus.tx_ready;

    // Counting the in-flight word reserves its slot, so a read is only
    // issued when the FIFO is guaranteed to have room on arrival.
    assign occ = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign oen = (state_q == ST_RUN) && en && (occ < (CW+1)'(FIFO_DEPTH));

    assign bus.a2s_oen  = oen;
    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_i     = fifo_empty ? '0 : mem_i_q[rptr_q];
    assign bus.tx_q     = fifo_empty ? '0 : mem_q_q[rptr_q];
    assign underrun     = underrun_q;
    assign sat_flag     = sat_q;
    assign smp_cnt      = cnt_q;

    always_ff @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prime_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            underrun_q <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (sync) begin
            state_q    <= ST_IDLE;
            prime_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            underrun_q <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= oen;
            count_q    <= count_q + CW'(push) - CW'(pop);

            if (push) begin
                wptr_q <= wptr_q + 1'b1;
                if (sat_i || sat_qc) sat_q <= 1'b1;
            end

            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end

            if ((state_q == ST_RUN) && bus.tx_ready && fifo_empty) underrun_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_PRIME;
                        prime_q <= '0;
                    end
                end
                ST_PRIME: begin
                    if (!en)                                state_q <= ST_IDLE;
                    else if (prime_q == PW'(PRIME_CYCLES - 1)) state_q <= ST_RUN;
                    else                                    prime_q <= prime_q + 1'b1;
                end
                ST_RUN: begin
                    if (!en) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty && !inflight_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sample storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge Sclk) begin
        if (push) begin
            mem_i_q[wptr_q] <= rnd_i;
            mem_q_q[wptr_q] <= rnd_q;
        end
    end
endmodule
